// File: rtl/avalon_led_pio_pkg.sv
// Shared constants for the avalon_led_pio LED port.
// Register addresses and register reset values.
package avalon_led_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK    = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_DUTY     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [31:0] BLINK_RST    = 32'd0;
    localparam logic [31:0] PRESCALE_RST = 32'd0;
    localparam logic [15:0] DUTY_RST     = 16'hFFFF;

endpackage

// File: rtl/avalon_led_pio_if.sv
// Avalon-MM slave bus bundle for avalon_led_pio.
// Master drives address/strobes, slave returns registered readdata.
interface avalon_led_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_led_pio_tick_gen.sv
// led_tick_gen: programmable prescaler with tick and phase outputs.
// A load pulse restarts the count without touching the phase.
module led_tick_gen #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] prescale,
    input  logic         load,
    output logic         tick,
    output logic         phase
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] pcnt;

    // A load on the wrap cycle wins, so no tick is emitted then.
    assign tick = !load && (pcnt == prescale);

    // Counter wraps at prescale and flips phase on every tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt  <= '0;
            phase <= 1'b1;
        end else if (load) begin
            pcnt  <= '0;
        end else if (tick) begin
            pcnt  <= '0;
            phase <= ~phase;
        end else begin
            pcnt  <= pcnt + ONE;
        end
    end

endmodule

// File: rtl/avalon_led_pio.sv
// avalon_led_pio: Avalon-MM LED port with set/clear, blink and PWM dim.
// Optional PWM dimming is built only when LED_PWM_EN is defined.
module avalon_led_pio
    import avalon_led_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               PRESCALE_W  = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PWM_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    avalon_led_pio_if.slave  bus,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]      data;
    logic [WIDTH-1:0]      blink;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      wd;
    logic [31:0]           rd;
    logic                  wr;
    logic                  load;
    logic                  tick;
    logic                  phase;
    logic                  pwm_on;
    logic                  unused_ok;

    assign wr   = bus.chipselect && !bus.write_n;
    assign wd   = bus.writedata[WIDTH-1:0];
    assign load = wr && (bus.address == ADDR_PRESCALE);

    assign unused_ok = ^{bus.writedata, tick};

    led_tick_gen #(
        .W(PRESCALE_W)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .prescale(prescale),
        .load    (load),
        .tick    (tick),
        .phase   (phase)
    );

`ifdef LED_PWM_EN
    localparam logic [PWM_W-1:0] W_ONE = 1;

    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] wcnt;

    assign pwm_on = (wcnt < duty) || (duty == '1);

    // DUTY register and free-running PWM counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty <= DUTY_RST[PWM_W-1:0];
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + W_ONE;
            if (wr && bus.address == ADDR_DUTY)
                duty <= bus.writedata[PWM_W-1:0];
        end
    end
`else
    assign pwm_on = 1'b1;
`endif

    // Register writes; OUTSET/OUTCLEAR modify DATA atomically.
    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= RESET_VALUE;
            blink    <= BLINK_RST[WIDTH-1:0];
            prescale <= PRESCALE_RST[PRESCALE_W-1:0];
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:     data     <= wd;
                ADDR_BLINK:    blink    <= wd;
                ADDR_PRESCALE: prescale <= bus.writedata[PRESCALE_W-1:0];
                ADDR_OUTSET:   data     <= data | wd;
                ADDR_OUTCLEAR: data     <= data & ~wd;
                default:       ;
            endcase
        end
    end

    // Read mux: zero-extended register for the current address.
    always_comb begin
        rd = '0;
        case (bus.address)
            ADDR_DATA:     rd[WIDTH-1:0]      = data;
            ADDR_BLINK:    rd[WIDTH-1:0]      = blink;
            ADDR_PRESCALE: rd[PRESCALE_W-1:0] = prescale;
`ifdef LED_PWM_EN
            ADDR_DUTY:     rd[PWM_W-1:0]      = duty;
`endif
            default:       rd = '0;
        endcase
    end

    // Registered readdata and LED drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
            out_port     <= RESET_VALUE;
        end else begin
            bus.readdata <= rd;
            out_port     <= data & (~blink | {WIDTH{phase}})
                                 & {WIDTH{pwm_on}};
        end
    end

endmodule

// File: doc/avalon_led_pio.md
Name: avalon_led_pio

Overview:
- Parametrised successor to the fixed 8-bit LED output port: Avalon-MM slave driving WIDTH output pins.
- Adds atomic set/clear writes, per-channel hardware blink from a programmable prescaler, and global PWM dimming.
- Sits on the system interconnect as a Qsys peripheral.
- Read latency is 1 cycle (registered readdata).

Parameters:
- WIDTH, 8, number of output channels (1..32).
- PRESCALE_W, 24, width of the blink prescaler register and counter (1..32).
- RESET_VALUE, 0, value loaded into DATA on reset; WIDTH bits.
- PWM_W, 8, width of the PWM counter and DUTY register (1..16).

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data, valid 1 cycle after address is presented.
- out_port  out  WIDTH  LED drive.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on port `reset`.
- Register map (addr: name, access):
  - 0 DATA (RW, WIDTH bits)
  - 1 BLINK (RW, WIDTH-bit mask)
  - 2 PRESCALE (RW, PRESCALE_W bits)
  - 3 DUTY (RW, PWM_W bits)
  - 4 OUTSET (WO; DATA |= wd)
  - 5 OUTCLEAR (WO; DATA &= ~wd)
  - 6, 7 reserved: reads return 0, writes are ignored.
- Write strobe: a write occurs when chipselect=1 and write_n=0. The register updates on that clk edge. Unused high bits of writedata are ignored.
- Reads:
  - readdata <= zero-extended register for the current address, every cycle, independent of chipselect.
  - WO addresses read 0.
- Reset values:
  - DATA=RESET_VALUE, BLINK=0, PRESCALE=0, DUTY=all-ones.
  - Prescale counter=0, phase=1, PWM counter=0.
  - readdata=0.
  - out_port=RESET_VALUE one cycle after reset deasserts. During reset, out_port is also RESET_VALUE because it is fed from reset registers.
- Prescaler:
  - pcnt increments each cycle.
  - When pcnt==PRESCALE, the block emits a 1-cycle tick, pcnt returns to 0 and phase toggles.
  - Blink half-period is therefore PRESCALE+1 cycles. PRESCALE=0 toggles phase every cycle.
  - A write to PRESCALE forces pcnt to 0 on the same edge and leaves phase unchanged. If a tick would have occurred on that edge, it is suppressed.
- PWM:
  - wcnt is a free-running PWM_W-bit up-counter that wraps from all-ones to 0.
  - pwm_on = (wcnt < DUTY) OR (DUTY == all-ones).
  - DUTY=0 means always off. All-ones means always on (no missing cycle).
- Output (registered, 1 cycle behind its inputs): out_port[i] <= DATA[i] & (BLINK[i] ? phase : 1) & pwm_on.
- Simultaneous events:
  - Only one register is written per cycle (single address).
  - Internal counter updates coincide with writes. The written register value takes effect on the next cycle's output computation.
- Reset mid-operation: all state returns to reset values on the next edge. Blink and PWM restart from phase=1, wcnt=0.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined: the DUTY register and PWM counter exist as described above.
- Not defined:
  - No wcnt or DUTY storage.
  - Address 3 reads 0 and ignores writes.
  - pwm_on is constant 1.

Decomposition:
- Package avalon_led_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLEAR (3'd0..3'd5);
  - reset constants for BLINK, PRESCALE and DUTY.
- One sub-module, led_tick_gen: the prescale counter with load-clear input, tick output and phase flop. It is reused by later timer/LED peripherals.
- The PWM comparator stays inline.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0 after reset, and a read of addr 0 returns 32'h000000A5 one cycle after address is applied.
- Write DATA=8'h0F, then OUTSET 8'hF0, then OUTCLEAR 8'h3C -> DATA reads back 8'h0F, then 8'hFF, then 8'hC3. out_port follows 1 cycle after each write.
- PRESCALE=3, BLINK=8'h01, DATA=8'h01 -> out_port[0] is 1 for 4 cycles, then 0 for 4 cycles, repeating. Rewriting PRESCALE=3 mid-period restarts the 4-cycle count without toggling phase.
- LED_PWM_EN defined, PWM_W=8, DUTY=64, DATA=8'hFF -> each bit high exactly 64 of every 256 cycles. DUTY=0 -> always low. DUTY=255 -> always high.
- Without LED_PWM_EN: write 8'h10 to addr 3 -> read returns 0 and out_port is unaffected. Reserved addresses 6 and 7 read 0.
- Assert reset for 1 cycle during active blink and PWM -> the next cycle shows reset values, and blink restarts with phase=1 counting from 0.
